// File: rtl/maze_pkg.sv
// Shared types and constants for the maze player-movement slice.
package maze_pkg;

  localparam int MAZE_Y = 20;
  localparam int MAZE_X = 40;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READY,
    ST_COOLDOWN,
    ST_DONE
  } mover_state_t;

endpackage

// File: rtl/player_mover_if.sv
// Bundle of controls, constraint maps and status between the maze logic and the mover.
interface player_mover_if #(
  parameter int size_y = maze_pkg::MAZE_Y,
  parameter int size_x = maze_pkg::MAZE_X
);
  localparam int YW = $clog2(size_y);
  localparam int XW = $clog2(size_x);

  logic          start;
  logic          frame_tick;
  logic          key_up;
  logic          key_down;
  logic          key_left;
  logic          key_right;
  // Indexed [row][column]; a set bit blocks leaving that cell in that direction.
  logic [0:size_x-1] up_constraint    [size_y-1:0];
  logic [0:size_x-1] down_constraint  [size_y-1:0];
  logic [0:size_x-1] left_constraint  [size_y-1:0];
  logic [0:size_x-1] right_constraint [size_y-1:0];
  logic [YW-1:0] goal_y;
  logic [XW-1:0] goal_x;
  logic [YW-1:0] player_y;
  logic [XW-1:0] player_x;
  logic          moved;
  logic          at_goal;
  logic [15:0]   move_count;

  modport master (
    output start, frame_tick, key_up, key_down, key_left, key_right,
    output up_constraint, down_constraint, left_constraint, right_constraint,
    output goal_y, goal_x,
    input  player_y, player_x, moved, at_goal, move_count
  );

  modport slave (
    input  start, frame_tick, key_up, key_down, key_left, key_right,
    input  up_constraint, down_constraint, left_constraint, right_constraint,
    input  goal_y, goal_x,
    output player_y, player_x, moved, at_goal, move_count
  );

endinterface

// File: rtl/move_arbiter.sv
// Picks the single highest-priority key edge and vets it against walls and maze edges.
module move_arbiter
  import maze_pkg::*;
#(
  parameter int size_y = MAZE_Y,
  parameter int size_x = MAZE_X,
  localparam int YW = $clog2(size_y),
  localparam int XW = $clog2(size_x)
) (
  input  logic          req_up,
  input  logic          req_down,
  input  logic          req_left,
  input  logic          req_right,
  input  logic          blk_up,
  input  logic          blk_down,
  input  logic          blk_left,
  input  logic          blk_right,
  input  logic [YW-1:0] cur_y,
  input  logic [XW-1:0] cur_x,
  output dir_t          dir
);

  // Only the top-priority request is examined; a blocked winner yields no move at all.
  always_comb begin
    dir = DIR_NONE;
    if (req_up) begin
      if (!blk_up && (cur_y != YW'(size_y - 1))) dir = DIR_UP;
    end else if (req_down) begin
      if (!blk_down && (cur_y != '0)) dir = DIR_DOWN;
    end else if (req_left) begin
      if (!blk_left && (cur_x != '0)) dir = DIR_LEFT;
    end else if (req_right) begin
      if (!blk_right && (cur_x != XW'(size_x - 1))) dir = DIR_RIGHT;
    end
  end

endmodule

// File: rtl/player_mover.sv
// Player position register with edge-triggered moves, frame-based cooldown and goal detect.
module player_mover
  import maze_pkg::*;
#(
  parameter int size_y   = MAZE_Y,
  parameter int size_x   = MAZE_X,
  parameter int START_Y  = 0,
  parameter int START_X  = 0,
  parameter int COOLDOWN = 8
) (
  input logic          clk,
  input logic          reset_n,
  player_mover_if.slave bus
);

  localparam int YW = $clog2(size_y);
  localparam int XW = $clog2(size_x);

  // Key order in the vectors below: {up, down, left, right}.
  logic [3:0]    key_s;
  logic [3:0]    key_q;
  logic [3:0]    key_edge;
  mover_state_t  state;
  logic [YW-1:0] pos_y;
  logic [XW-1:0] pos_x;
  logic          moved_reg;
  logic          at_goal_reg;
  logic [15:0]   count_reg;
  logic [7:0]    cool_reg;
  logic          at_goal_pos;
  dir_t          dir;

  assign key_edge    = key_s & ~key_q;
  assign at_goal_pos = (pos_y == bus.goal_y) && (pos_x == bus.goal_x);

  move_arbiter #(.size_y(size_y), .size_x(size_x)) u_arb (
    .req_up    (key_edge[3]),
    .req_down  (key_edge[2]),
    .req_left  (key_edge[1]),
    .req_right (key_edge[0]),
    .blk_up    (bus.up_constraint[pos_y][pos_x]),
    .blk_down  (bus.down_constraint[pos_y][pos_x]),
    .blk_left  (bus.left_constraint[pos_y][pos_x]),
    .blk_right (bus.right_constraint[pos_y][pos_x]),
    .cur_y     (pos_y),
    .cur_x     (pos_x),
    .dir       (dir)
  );

  // Register keys twice: first stage aligns them to clk, second gives the previous level for edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_s <= '0;
      key_q <= '0;
    end else begin
      key_s <= {bus.key_up, bus.key_down, bus.key_left, bus.key_right};
      key_q <= key_s;
    end
  end

  // Mover FSM: start always re-arms, goal check overrides cooldown, outputs all registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pos_y       <= YW'(START_Y);
      pos_x       <= XW'(START_X);
      moved_reg   <= 1'b0;
      at_goal_reg <= 1'b0;
      count_reg   <= '0;
      cool_reg    <= '0;
    end else begin
      moved_reg <= 1'b0;
      if (bus.start) begin
        state       <= ST_READY;
        pos_y       <= YW'(START_Y);
        pos_x       <= XW'(START_X);
        at_goal_reg <= 1'b0;
        count_reg   <= '0;
        cool_reg    <= '0;
      end else begin
        case (state)
          ST_READY: begin
            if (at_goal_pos) begin
              state       <= ST_DONE;
              at_goal_reg <= 1'b1;
            end else if (dir != DIR_NONE) begin
              case (dir)
                DIR_UP:    pos_y <= pos_y + YW'(1);
                DIR_DOWN:  pos_y <= pos_y - YW'(1);
                DIR_LEFT:  pos_x <= pos_x - XW'(1);
                DIR_RIGHT: pos_x <= pos_x + XW'(1);
                default:   ;
              endcase
              moved_reg <= 1'b1;
              if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
              cool_reg  <= 8'(COOLDOWN);
              state     <= ST_COOLDOWN;
            end
          end
          ST_COOLDOWN: begin
            if (at_goal_pos) begin
              state       <= ST_DONE;
              at_goal_reg <= 1'b1;
            end else if (bus.frame_tick) begin
              if (cool_reg <= 8'd1) begin
                cool_reg <= '0;
                state    <= ST_READY;
              end else begin
                cool_reg <= cool_reg - 8'd1;
              end
            end
          end
          default: ;  // IDLE and DONE wait for start
        endcase
      end
    end
  end

  assign bus.player_y   = pos_y;
  assign bus.player_x   = pos_x;
  assign bus.moved      = moved_reg;
  assign bus.at_goal    = at_goal_reg;
  assign bus.move_count = count_reg;

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: movement, walls, maze edges, cooldown, goal and reset.
module tb_player_mover;

  localparam int SY = 20;
  localparam int SX = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  player_mover_if #(.size_y(SY), .size_x(SX)) bus ();

  player_mover #(
    .size_y(SY), .size_x(SX), .START_Y(0), .START_X(0), .COOLDOWN(8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Keys ordered {up, down, left, right}; returns on the cycle a move would show.
  task automatic press(input logic [3:0] k);
    {bus.key_up, bus.key_down, bus.key_left, bus.key_right} = k;
    step();
    step();
  endtask

  task automatic release_keys();
    {bus.key_up, bus.key_down, bus.key_left, bus.key_right} = 4'b0000;
    step();
    step();
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic clear_constraints();
    for (int y = 0; y < SY; y++) begin
      bus.up_constraint[y]    = '0;
      bus.down_constraint[y]  = '0;
      bus.left_constraint[y]  = '0;
      bus.right_constraint[y] = '0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.player_y, bus.player_x} !== {5'd0, 6'd0}) begin
      errors++; $display("FAIL reset_pos: got (%0d,%0d) want (0,0)", bus.player_y, bus.player_x);
    end
    checks++;
    if ({bus.moved, bus.at_goal, bus.move_count} !== {1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL reset_flags: moved=%0d at_goal=%0d count=%0d want 0/0/0",
                         bus.moved, bus.at_goal, bus.move_count);
    end
    press(4'b1000);
    checks++;
    if ({bus.player_y, bus.moved} !== {5'd0, 1'b0}) begin
      errors++; $display("FAIL idle_ignores_key: y=%0d moved=%0d want 0/0", bus.player_y, bus.moved);
    end
    release_keys();
    $display("test_reset done");
  endtask

  task automatic test_move_cooldown();
    pulse_start();
    press(4'b1000);
    checks++;
    if ({bus.player_y, bus.player_x, bus.moved} !== {5'd1, 6'd0, 1'b1}) begin
      errors++; $display("FAIL first_up: got (%0d,%0d) moved=%0d want (1,0) moved=1",
                         bus.player_y, bus.player_x, bus.moved);
    end
    checks++;
    if (bus.move_count !== 16'd1) begin
      errors++; $display("FAIL first_up_count: got %0d want 1", bus.move_count);
    end
    release_keys();
    checks++;
    if (bus.moved !== 1'b0) begin
      errors++; $display("FAIL moved_one_cycle: got %0d want 0", bus.moved);
    end
    tick(); tick();
    press(4'b1000);
    checks++;
    if ({bus.player_y, bus.moved, bus.move_count} !== {5'd1, 1'b0, 16'd1}) begin
      errors++; $display("FAIL cooldown_ignore: y=%0d moved=%0d count=%0d want 1/0/1",
                         bus.player_y, bus.moved, bus.move_count);
    end
    release_keys();
    repeat (5) tick();
    press(4'b1000);
    checks++;
    if (bus.player_y !== 5'd1) begin
      errors++; $display("FAIL cooldown_7_ticks: y=%0d want 1", bus.player_y);
    end
    release_keys();
    tick();
    press(4'b1000);
    checks++;
    if ({bus.player_y, bus.moved, bus.move_count} !== {5'd2, 1'b1, 16'd2}) begin
      errors++; $display("FAIL cooldown_expired: y=%0d moved=%0d count=%0d want 2/1/2",
                         bus.player_y, bus.moved, bus.move_count);
    end
    release_keys();
    $display("test_move_cooldown done");
  endtask

  task automatic test_constraint();
    bus.up_constraint[0][0] = 1'b1;
    pulse_start();
    checks++;
    if ({bus.player_y, bus.player_x, bus.move_count} !== {5'd0, 6'd0, 16'd0}) begin
      errors++; $display("FAIL start_restore: (%0d,%0d) count=%0d want (0,0) 0",
                         bus.player_y, bus.player_x, bus.move_count);
    end
    press(4'b1000);
    checks++;
    if ({bus.player_y, bus.moved} !== {5'd0, 1'b0}) begin
      errors++; $display("FAIL wall_up: y=%0d moved=%0d want 0/0", bus.player_y, bus.moved);
    end
    release_keys();
    press(4'b0001);
    checks++;
    if ({bus.player_y, bus.player_x, bus.moved} !== {5'd0, 6'd1, 1'b1}) begin
      errors++; $display("FAIL right_after_wall: (%0d,%0d) moved=%0d want (0,1) 1",
                         bus.player_y, bus.player_x, bus.moved);
    end
    release_keys();
    clear_constraints();
    $display("test_constraint done");
  endtask

  task automatic test_boundary();
    pulse_start();
    press(4'b0100);
    checks++;
    if ({bus.player_y, bus.player_x, bus.move_count} !== {5'd0, 6'd0, 16'd0}) begin
      errors++; $display("FAIL edge_down: (%0d,%0d) count=%0d want (0,0) 0",
                         bus.player_y, bus.player_x, bus.move_count);
    end
    release_keys();
    press(4'b0010);
    checks++;
    if ({bus.player_y, bus.player_x, bus.move_count, bus.moved} !== {5'd0, 6'd0, 16'd0, 1'b0}) begin
      errors++; $display("FAIL edge_left: (%0d,%0d) count=%0d moved=%0d want (0,0) 0 0",
                         bus.player_y, bus.player_x, bus.move_count, bus.moved);
    end
    release_keys();
    $display("test_boundary done");
  endtask

  task automatic test_priority();
    pulse_start();
    press(4'b1001);
    checks++;
    if ({bus.player_y, bus.player_x, bus.move_count} !== {5'd1, 6'd0, 16'd1}) begin
      errors++; $display("FAIL up_over_right: (%0d,%0d) count=%0d want (1,0) 1",
                         bus.player_y, bus.player_x, bus.move_count);
    end
    release_keys();
    $display("test_priority done");
  endtask

  task automatic test_goal();
    bus.goal_y = 5'd0;
    bus.goal_x = 6'd1;
    pulse_start();
    press(4'b0001);
    checks++;
    if ({bus.player_x, bus.moved, bus.at_goal} !== {6'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL goal_move: x=%0d moved=%0d at_goal=%0d want 1/1/0",
                         bus.player_x, bus.moved, bus.at_goal);
    end
    step();
    checks++;
    if (bus.at_goal !== 1'b1) begin
      errors++; $display("FAIL goal_flag: got %0d want 1", bus.at_goal);
    end
    release_keys();
    press(4'b1000);
    checks++;
    if ({bus.player_y, bus.player_x, bus.at_goal} !== {5'd0, 6'd1, 1'b1}) begin
      errors++; $display("FAIL done_ignores_key: (%0d,%0d) at_goal=%0d want (0,1) 1",
                         bus.player_y, bus.player_x, bus.at_goal);
    end
    release_keys();
    pulse_start();
    checks++;
    if ({bus.player_y, bus.player_x, bus.at_goal, bus.move_count} !== {5'd0, 6'd0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL done_restart: (%0d,%0d) at_goal=%0d count=%0d want (0,0) 0 0",
                         bus.player_y, bus.player_x, bus.at_goal, bus.move_count);
    end
    // Goal placed on the start cell: DONE one cycle after start.
    bus.goal_x = 6'd0;
    pulse_start();
    checks++;
    if (bus.at_goal !== 1'b0) begin
      errors++; $display("FAIL start_goal_early: at_goal=%0d want 0", bus.at_goal);
    end
    step();
    checks++;
    if (bus.at_goal !== 1'b1) begin
      errors++; $display("FAIL start_goal_late: at_goal=%0d want 1", bus.at_goal);
    end
    bus.goal_y = 5'd5;
    bus.goal_x = 6'd5;
    $display("test_goal done");
  endtask

  task automatic test_async_reset();
    logic [3:0] path [7];
    path = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      press(path[i]);
      release_keys();
      if (i < 6) repeat (8) tick();
    end
    checks++;
    if ({bus.player_y, bus.player_x, bus.move_count} !== {5'd3, 6'd4, 16'd7}) begin
      errors++; $display("FAIL walk_to_3_4: (%0d,%0d) count=%0d want (3,4) 7",
                         bus.player_y, bus.player_x, bus.move_count);
    end
    tick(); tick();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.player_y, bus.player_x, bus.moved, bus.at_goal, bus.move_count}
        !== {5'd0, 6'd0, 1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL async_reset: (%0d,%0d) moved=%0d at_goal=%0d count=%0d want zeros",
                         bus.player_y, bus.player_x, bus.moved, bus.at_goal, bus.move_count);
    end
    step(); step();
    reset_n = 1'b1;
    step();
    press(4'b1000);
    checks++;
    if ({bus.player_y, bus.moved} !== {5'd0, 1'b0}) begin
      errors++; $display("FAIL post_reset_idle: y=%0d moved=%0d want 0/0", bus.player_y, bus.moved);
    end
    release_keys();
    pulse_start();
    press(4'b1000);
    checks++;
    if ({bus.player_y, bus.moved, bus.move_count} !== {5'd1, 1'b1, 16'd1}) begin
      errors++; $display("FAIL post_reset_move: y=%0d moved=%0d count=%0d want 1/1/1",
                         bus.player_y, bus.moved, bus.move_count);
    end
    release_keys();
    $display("test_async_reset done");
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.frame_tick = 1'b0;
    {bus.key_up, bus.key_down, bus.key_left, bus.key_right} = 4'b0000;
    bus.goal_y = 5'd5;
    bus.goal_x = 6'd5;
    clear_constraints();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    test_reset();
    test_move_cooldown();
    test_constraint();
    test_boundary();
    test_priority();
    test_goal();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_mover.md
Name: player_mover

Overview:
- Consumes the per-cell direction-constraint arrays produced by the four constraint checkers (up, down, left, right) and moves the player one cell per accepted key press.
- Registers player position, enforces a frame-tick move cooldown, counts moves, and flags arrival at the goal cell.
- Sits between the constraint-checker stage and the sprite/draw logic, which reads player_y/player_x.

Parameters:
- size_y, 20, maze rows; row index 0..size_y-1.
- size_x, 40, maze columns; column index 0..size_x-1.
- START_Y, 0, player row after reset or start.
- START_X, 0, player column after reset or start.
- COOLDOWN, 8, frame_ticks that must elapse after a move before the next move is accepted (1..255).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: (re)place player at START and arm.
- frame_tick  in  1  one-cycle strobe per video frame.
- key_up, key_down, key_left, key_right  in  1 each  level-sensitive key inputs.
- up_constraint, down_constraint, left_constraint, right_constraint  in  [0:size_x-1] x [size_y-1:0] each  bit = 1: move from that cell in that direction is blocked.
- goal_y  in  $clog2(size_y)  goal row.
- goal_x  in  $clog2(size_x)  goal column.
- player_y  out  $clog2(size_y)  current row.
- player_x  out  $clog2(size_x)  current column.
- moved  out  1  one-cycle pulse on the cycle the position register updates.
- at_goal  out  1  high while the FSM is in DONE.
- move_count  out  16  accepted moves since start; saturates at 16'hFFFF.

Behaviour:
- Direction mapping: up = y+1, down = y-1, left = x-1, right = x+1.
- Reset (async, reset_n low): state IDLE, player_y=START_Y, player_x=START_X, moved=0, at_goal=0, move_count=0, cooldown counter=0.
- FSM states IDLE, READY, COOLDOWN, DONE.
  - IDLE: ignores keys; start -> READY.
  - READY: a key is detected on its rising edge (each key registered once; edge = key & ~key_q). Edge requests are prioritised up > down > left > right; only the highest is considered. The request is legal iff its constraint bit at [player_y][player_x] is 0 and the target is inside 0..size_y-1 / 0..size_x-1. Edges are forced blocked regardless of the constraint bit.
    - Legal request: position updates on the next clock edge, moved=1 for that cycle, move_count increments, cooldown counter loads COOLDOWN, state -> COOLDOWN.
    - Illegal request: no change, no pulse, stays READY.
  - COOLDOWN: decrements on each frame_tick; key edges are discarded, not queued. When the counter reaches 0, state -> READY.
  - Goal check: evaluated on the registered position after every update. If (player_y,player_x)==(goal_y,goal_x), state -> DONE, overriding COOLDOWN.
  - DONE: at_goal=1, keys ignored; start -> READY at START.
- start in any state, including mid-cooldown: position=START, move_count=0, counter=0, state READY on the next cycle; start wins over a simultaneous key edge. If START equals the goal, the state goes to DONE one cycle later.
- Latency: key edge to position/moved = 1 clock after the edge is registered (2 clocks from the raw key rising).
- moved and at_goal are registered outputs; there are no combinational paths from inputs to outputs.
- A key held through COOLDOWN does not auto-repeat; the player must release and press again.

Decomposition:
- Shared package maze_pkg:
  - typedef dir_t {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};
  - typedef mover_state_t;
  - constants MAZE_Y=20, MAZE_X=40.
- One sub-module: move_arbiter (combinational). It takes the four edge requests and the four constraint bits at the current cell and returns the dir_t to take (DIR_NONE when blocked, including boundary checks).

Test Plan:
1. Reset, then start, with all constraints 0 and goal (5,5): pulse key_up -> player (1,0), moved one cycle, move_count=1; a second key_up 2 frame_ticks later is ignored (COOLDOWN=8).
2. up_constraint[0][0]=1: start, key_up -> no move, no moved pulse; then key_right -> (0,1).
3. Boundary: at (0,0), key_down and key_left with constraint bits 0 -> position stays (0,0), move_count=0.
4. key_up and key_right rising in the same cycle at (0,0) -> move to (1,0) only.
5. Goal (0,1): key_right -> at_goal=1 on the cycle after moved, state DONE; further keys ignored; start -> (0,0), at_goal=0, move_count=0.
6. Assert reset_n low mid-COOLDOWN at (3,4) -> outputs immediately return to reset values without a clock edge; state IDLE; keys ignored until start.
